// File: rtl/add_pkg.sv
// Shared constants and state encoding for the byte-serial add/subtract sequencer.
package add_pkg;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    // Width of the shared adder slice; fixed by the add module.
    localparam int   SLICE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/add.sv
// Purely combinational 8-bit adder slice with carry in/out.
module add
    import add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    // Widen to SLICE_W+1 so the top bit carries out.
    assign {cout, s} = (SLICE_W+1)'(a) + (SLICE_W+1)'(b) + (SLICE_W+1)'(cin);

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle wide add/subtract: one shared 8-bit slice walked LSB-first,
// carry threaded through a register. Subtract is a + ~b + 1.
module add_seq_ctrl
    import add_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     op,
    input  logic [WORDS*SLICE_W-1:0] a,
    input  logic [WORDS*SLICE_W-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic [WORDS*SLICE_W-1:0] result,
    output logic                     cout,
    output logic                     ovf,
    output logic                     zero
);

    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    state_e                          state_q, state_d;
    logic [KW-1:0]                   k_q, k_d;
    logic                            carry_q, carry_d;
    logic                            op_q, op_d;
    logic [WORDS-1:0][SLICE_W-1:0]   a_q, a_d;
    logic [WORDS-1:0][SLICE_W-1:0]   b_q, b_d;
    logic [WORDS-1:0][SLICE_W-1:0]   acc_q, acc_d;
    logic [WORDS-1:0][SLICE_W-1:0]   result_q, result_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            cout_q, cout_d;
    logic                            ovf_q, ovf_d;
    logic                            zero_q, zero_d;

    logic [SLICE_W-1:0]              sl_a, sl_b, sl_s;
    logic                            sl_co;

    // k-indexed operand mux into the shared slice; b inverted for subtract.
    always_comb begin
        sl_a = a_q[k_q];
        sl_b = (op_q == OP_SUB) ? ~b_q[k_q] : b_q[k_q];
    end

    add u_add (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_co)
    );

    // Next-state: accept in IDLE, one slice per cycle in RUN, publish on last slice.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = op;   // +1 of the two's-complement negate
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d[k_q] = sl_s;
                carry_d    = sl_co;
                k_d        = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    // acc_d already includes this slice, so no partial sum escapes.
                    result_d = acc_d;
                    cout_d   = sl_co;
                    ovf_d    = (sl_a[SLICE_W-1] == sl_b[SLICE_W-1]) &&
                               (sl_s[SLICE_W-1] != sl_a[SLICE_W-1]);
                    zero_d   = (acc_d == '0);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (WORDS=2 and WORDS=4) with a queue scoreboard.
module tb_add_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start2 = 1'b0, op2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0;
    logic        busy2, done2, cout2, ovf2, zero2;
    logic [15:0] res2;

    logic        start4 = 1'b0, op4 = 1'b0;
    logic [31:0] a4 = '0, b4 = '0;
    logic        busy4, done4, cout4, ovf4, zero4;
    logic [31:0] res4;

    int tests = 0, fails = 0, cyc = 0;
    logic [34:0] q2[$], q4[$];
    int cnt2 = 0, cnt4 = 0;
    logic prev_done2 = 1'b0, prev_done4 = 1'b0;
    int last_done2 = -1, done_gap2 = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(.WORDS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(res2), .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    add_seq_ctrl #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    // Reference: {ovf, zero, cout, result} for a w-bit add/subtract.
    function automatic logic [34:0] model(int w, logic op, logic [31:0] a, logic [31:0] b);
        logic [32:0] mask, sum;
        logic [31:0] aa, bb, r;
        logic c, o, z;
        mask = (33'd1 << w) - 33'd1;
        aa   = a & mask[31:0];
        bb   = (op ? ~b : b) & mask[31:0];
        sum  = {1'b0, aa} + {1'b0, bb} + {32'd0, op};
        r    = sum[31:0] & mask[31:0];
        c    = sum[w];
        o    = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        z    = (r == 32'd0);
        return {o, z, c, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle-level model of acceptance/latency for one instance.
    task automatic mstep(input int w, input logic st, input logic op,
                         input logic [31:0] a, input logic [31:0] b,
                         inout int cnt, output logic exp_done,
                         output logic push, output logic [34:0] val);
        exp_done = 1'b0;
        push     = 1'b0;
        val      = model(w, op, a, b);
        if (cnt > 0) begin
            cnt--;
            exp_done = (cnt == 0);
        end else if (st) begin
            push = 1'b1;
            cnt  = w / 8;
        end
    endtask

    task automatic tick();
        logic ed2, ed4, p2, p4;
        logic [34:0] v2, v4, e;
        @(posedge clk);
        cyc++;
        mstep(16, start2, op2, {16'd0, a2}, {16'd0, b2}, cnt2, ed2, p2, v2);
        mstep(32, start4, op4, a4, b4, cnt4, ed4, p4, v4);
        if (p2) q2.push_back(v2);
        if (p4) q4.push_back(v4);
        #1;
        chk("done2", done2, ed2);
        chk("busy2", busy2, cnt2 != 0);
        chk("dbl_done2", prev_done2 && done2, 1'b0);
        if (ed2 && q2.size() != 0) begin
            e = q2.pop_front();
            chk("res2", res2, e[15:0]);
            chk("cout2", cout2, e[32]);
            chk("zero2", zero2, e[33]);
            chk("ovf2", ovf2, e[34]);
            if (last_done2 >= 0) done_gap2 = cyc - last_done2;
            last_done2 = cyc;
        end
        prev_done2 = done2;
        chk("done4", done4, ed4);
        chk("busy4", busy4, cnt4 != 0);
        if (ed4 && q4.size() != 0) begin
            e = q4.pop_front();
            chk("res4", res4, e[31:0]);
            chk("cout4", cout4, e[32]);
            chk("zero4", zero4, e[33]);
            chk("ovf4", ovf4, e[34]);
        end
        prev_done4 = done4;
    endtask

    task automatic run2(input logic op, input logic [15:0] a, input logic [15:0] b);
        start2 = 1'b1; op2 = op; a2 = a; b2 = b;
        tick();
        start2 = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy2, 1'b0);
        chk("rst_done", done2, 1'b0);
        chk("rst_res", res2, 16'h0);
        chk("rst_cout", cout2, 1'b0);
        chk("rst_ovf", ovf2, 1'b0);
        chk("rst_zero", zero2, 1'b0);
        chk("rst_res4", res4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Subtract, 2 words
        run2(1'b1, 16'h3AA2, 16'h044C);
        chk("sub_res", res2, 16'h3656);
        chk("sub_cout", cout2, 1'b1);
        chk("sub_ovf", ovf2, 1'b0);
        chk("sub_zero", zero2, 1'b0);

        // Add wrap to zero
        run2(1'b0, 16'hFFFF, 16'h0001);
        chk("wrap_res", res2, 16'h0000);
        chk("wrap_cout", cout2, 1'b1);
        chk("wrap_zero", zero2, 1'b1);
        chk("wrap_ovf", ovf2, 1'b0);

        // Subtract with borrow
        run2(1'b1, 16'h0000, 16'h0001);
        chk("borrow_res", res2, 16'hFFFF);
        chk("borrow_cout", cout2, 1'b0);
        chk("borrow_ovf", ovf2, 1'b0);

        // Signed overflow, add and subtract
        run2(1'b0, 16'h7FFF, 16'h0001);
        chk("ovfa_res", res2, 16'h8000);
        chk("ovfa_ovf", ovf2, 1'b1);
        chk("ovfa_cout", cout2, 1'b0);
        run2(1'b1, 16'h8000, 16'h0001);
        chk("ovfs_res", res2, 16'h7FFF);
        chk("ovfs_ovf", ovf2, 1'b1);
        chk("ovfs_cout", cout2, 1'b1);

        // start held 5 cycles with changing operands; model decides acceptance
        op2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start2 = 1'b1;
            a2 = 16'h0100 + 16'(i * 16'h0111);
            b2 = 16'h0203 + 16'(i * 16'h0050);
            tick();
        end
        start2 = 1'b0;
        repeat (4) tick();
        chk("hold_drained", q2.size(), 32'd0);

        // Second start in the done cycle: pulses 3 cycles apart
        start2 = 1'b1; op2 = 1'b0; a2 = 16'h0001; b2 = 16'h0002;
        tick();
        start2 = 1'b0;
        repeat (2) tick();
        chk("b2b_done1", done2, 1'b1);
        start2 = 1'b1; op2 = 1'b1; a2 = 16'h1000; b2 = 16'h0FFF;
        tick();
        start2 = 1'b0;
        repeat (2) tick();
        chk("b2b_gap", done_gap2, 32'd3);
        chk("b2b_res", res2, 16'h0001);

        // Async reset mid-operation
        start2 = 1'b1; op2 = 1'b0; a2 = 16'h1234; b2 = 16'h1111;
        tick();
        start2 = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy2, 1'b0);
        chk("mid_rst_done", done2, 1'b0);
        chk("mid_rst_res", res2, 16'h0);
        q2.delete(); q4.delete();
        cnt2 = 0; cnt4 = 0;
        prev_done2 = 1'b0; prev_done4 = 1'b0;
        last_done2 = -1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", busy2, 1'b0);
        run2(1'b0, 16'h0001, 16'h0001);
        chk("post_rst_res", res2, 16'h0002);
        chk("post_rst_cout", cout2, 1'b0);

        // 4-word instance subtract
        start4 = 1'b1; op4 = 1'b1; a4 = 32'h0001_0000; b4 = 32'h0000_0001;
        tick();
        start4 = 1'b0;
        repeat (3) tick();
        chk("w4_not_yet", done4, 1'b0);
        tick();
        chk("w4_done", done4, 1'b1);
        chk("w4_res", res4, 32'h0000_FFFF);
        chk("w4_cout", cout4, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
